// File: rtl/dplca_txop_table_ctrl_if.sv
// dplca_txop_table_ctrl_if: PLCA-side inputs and claim-table results of the DPLCA TXOP table manager.
// Inputs: dplca_aging, beacon_rx, txop_active, txop_id[7:0], plca_node_count[7:0].
// Outputs: dplca_txop_table_upd, dplca_new_age, dplca_txop_id[7:0], dplca_txop_node_count[7:0],
//   txop_claim_table_unpacked[511:0], max_hard_claim[7:0], pick_free_txop[7:0].
// DPLCA_TXOP_STATS_EN adds dplca_cycle_cnt[15:0] and dplca_overrun_cnt[7:0].
interface dplca_txop_table_ctrl_if;
    logic         dplca_aging;
    logic         beacon_rx;
    logic         txop_active;
    logic [7:0]   txop_id;
    logic [7:0]   plca_node_count;
    logic         dplca_txop_table_upd;
    logic         dplca_new_age;
    logic [7:0]   dplca_txop_id;
    logic [7:0]   dplca_txop_node_count;
    logic [511:0] txop_claim_table_unpacked;
    logic [7:0]   max_hard_claim;
    logic [7:0]   pick_free_txop;
`ifdef DPLCA_TXOP_STATS_EN
    logic [15:0]  dplca_cycle_cnt;
    logic [7:0]   dplca_overrun_cnt;
`endif
    modport master (
        output dplca_aging, beacon_rx, txop_active, txop_id, plca_node_count,
        input  dplca_txop_table_upd, dplca_new_age, dplca_txop_id, dplca_txop_node_count,
        input  txop_claim_table_unpacked, max_hard_claim, pick_free_txop
`ifdef DPLCA_TXOP_STATS_EN
        , input dplca_cycle_cnt, dplca_overrun_cnt
`endif
    );
    modport slave (
        input  dplca_aging, beacon_rx, txop_active, txop_id, plca_node_count,
        output dplca_txop_table_upd, dplca_new_age, dplca_txop_id, dplca_txop_node_count,
        output txop_claim_table_unpacked, max_hard_claim, pick_free_txop
`ifdef DPLCA_TXOP_STATS_EN
        , output dplca_cycle_cnt, dplca_overrun_cnt
`endif
    );
endinterface

// File: rtl/dplca_txop_table_ctrl.sv
// dplca_txop_table_ctrl: DPLCA TXOP claim table with per-beacon update, window aging and sequential result scan.
// Ports: clk (PLCA clock), plca_reset_n (async active-low reset),
//   bus (dplca_txop_table_ctrl_if.slave): beacon/TXOP activity in, HARD_CLAIMING / MAX_HARD_CLAIM /
//   PICK_FREE_TXOP results and the live claim table out.
// Optional: DPLCA_TXOP_STATS_EN adds saturating completed-cycle and aborted-scan counters.
module dplca_txop_table_ctrl #(
    parameter int DPLCA_AGING_CYCLES = 4,
    parameter int CLAIM_MAX = 3
) (
    input logic clk,
    input logic plca_reset_n,
    dplca_txop_table_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [255:0][1:0] tbl;
    logic [255:0] seen, set_vec, hit;
    logic [7:0] age_cnt, cycle_max, idx, lat_id, lat_cnt, mh_acc, pf_acc;
    logic aging_q, age_q, fall, age, done_ok;
`ifdef DPLCA_TXOP_STATS_EN
    logic overrun;
    assign overrun = bus.beacon_rx && !fall && state != IDLE;
`endif
    assign bus.txop_claim_table_unpacked = tbl;
    always_comb begin
        fall = aging_q && !bus.dplca_aging;
        age = bus.dplca_aging && age_cnt == 8'(DPLCA_AGING_CYCLES - 1);
        set_vec = '0;
        if (bus.txop_active) set_vec[bus.txop_id] = 1'b1;
        hit = seen | set_vec;
        done_ok = state == DONE && !bus.beacon_rx && !fall;
        // any beacon restarts at UPDATE; from a busy state this is an overrun that drops the pending result
        state_n = fall ? IDLE :
                  bus.beacon_rx ? UPDATE :
                  state == UPDATE ? SCAN :
                  (state == SCAN && idx == 8'hff) ? DONE :
                  state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge plca_reset_n) begin
        if (!plca_reset_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge plca_reset_n) begin
        if (!plca_reset_n) begin
            tbl <= '0;
            seen <= '0;
            age_cnt <= '0;
            cycle_max <= '0;
            idx <= '0;
            lat_id <= '0;
            lat_cnt <= '0;
            mh_acc <= '0;
            pf_acc <= 8'hff;
            aging_q <= 1'b0;
            age_q <= 1'b0;
            bus.dplca_txop_table_upd <= 1'b0;
            bus.dplca_new_age <= 1'b0;
            bus.dplca_txop_id <= '0;
            bus.dplca_txop_node_count <= '0;
            bus.max_hard_claim <= '0;
            bus.pick_free_txop <= 8'hff;
`ifdef DPLCA_TXOP_STATS_EN
            bus.dplca_cycle_cnt <= '0;
            bus.dplca_overrun_cnt <= '0;
`endif
        end else begin
            aging_q <= bus.dplca_aging;
            // a set in the same clock as the clear survives into the new window
            seen <= ((fall || (state == UPDATE && age)) ? '0 : seen) | set_vec;
            age_cnt <= (fall || !bus.dplca_aging || (state == UPDATE && age)) ? 8'd0 :
                       state == UPDATE ? age_cnt + 8'd1 : age_cnt;
            cycle_max <= bus.beacon_rx ? 8'd0 :
                         (bus.txop_active && bus.txop_id > cycle_max) ? bus.txop_id : cycle_max;
            for (int i = 0; i < 256; i++) begin
                if (fall) tbl[i] <= 2'd0;
                else if (state == UPDATE)
                    tbl[i] <= hit[i] ? 2'(CLAIM_MAX) : (age && tbl[i] != 2'd0) ? tbl[i] - 2'd1 : tbl[i];
            end
            if (bus.beacon_rx) begin
                lat_id <= bus.txop_id;
                lat_cnt <= cycle_max == 8'hff ? 8'hff : cycle_max + 8'd1;
            end
            idx <= state == SCAN ? idx + 8'd1 : 8'd0;
            if (state == UPDATE) begin
                age_q <= age;
                mh_acc <= '0;
                pf_acc <= 8'hff;
            end else if (state == SCAN) begin
                if (tbl[idx][1]) mh_acc <= idx;
                if (pf_acc == 8'hff && tbl[idx] == 2'd0 && idx != 8'd0 && idx < bus.plca_node_count)
                    pf_acc <= idx;
            end
            bus.dplca_txop_table_upd <= done_ok;
            bus.dplca_new_age <= done_ok && age_q;
            if (done_ok) begin
                bus.dplca_txop_id <= lat_id;
                bus.dplca_txop_node_count <= lat_cnt;
                bus.max_hard_claim <= mh_acc;
                bus.pick_free_txop <= pf_acc;
            end
`ifdef DPLCA_TXOP_STATS_EN
            bus.dplca_cycle_cnt <= fall ? 16'd0 :
                                   (done_ok && bus.dplca_cycle_cnt != 16'hffff) ? bus.dplca_cycle_cnt + 16'd1 :
                                   bus.dplca_cycle_cnt;
            bus.dplca_overrun_cnt <= fall ? 8'd0 :
                                     (overrun && bus.dplca_overrun_cnt != 8'hff) ? bus.dplca_overrun_cnt + 8'd1 :
                                     bus.dplca_overrun_cnt;
`endif
        end
    end
endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// tb_dplca_txop_table_ctrl: randomized and directed bench against an array-based claim-table model.
module tb_dplca_txop_table_ctrl;
    localparam int AGE_N = 4;
    logic clk = 1'b0;
    logic plca_reset_n = 1'b0;
    always #5 clk = ~clk;
    dplca_txop_table_ctrl_if bus();
    dplca_txop_table_ctrl dut (.clk(clk), .plca_reset_n(plca_reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int m_tbl[256];
    bit m_seen[256];
    int m_age_cnt, m_cm, m_exp_nc, m_exp_id, m_mh, m_pf, m_cycles, m_overruns;
    bit m_exp_age;

    function automatic logic [511:0] m_table();
        logic [511:0] t;
        for (int i = 0; i < 256; i++) t[2*i +: 2] = 2'(m_tbl[i]);
        return t;
    endfunction

    function automatic int m_max_hard();
        int r = 0;
        for (int i = 0; i < 256; i++) if (m_tbl[i] >= 2) r = i;
        return r;
    endfunction

    function automatic int m_pick_free(input int nc);
        for (int i = 1; i < nc; i++) if (m_tbl[i] == 0) return i;
        return 255;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_active(input int id);
        bus.txop_active = 1'b1;
        bus.txop_id = 8'(id);
        tick();
        bus.txop_active = 1'b0;
        m_seen[id] = 1'b1;
        if (id > m_cm) m_cm = id;
    endtask

    task automatic send_beacon(input int bid, input int extra, output int k);
        bit age;
        bus.beacon_rx = 1'b1;
        bus.txop_id = 8'(bid);
        tick();
        bus.beacon_rx = 1'b0;
        k = 0;
        if (extra >= 0) begin
            bus.txop_active = 1'b1;
            bus.txop_id = 8'(extra);
            tick();
            bus.txop_active = 1'b0;
            k = 1;
        end
        age = bus.dplca_aging && m_age_cnt == AGE_N - 1;
        for (int i = 0; i < 256; i++) begin
            if (m_seen[i] || i == extra) m_tbl[i] = 3;
            else if (age && m_tbl[i] > 0) m_tbl[i]--;
            m_seen[i] = (age ? 1'b0 : m_seen[i]) || i == extra;
        end
        m_age_cnt = age ? 0 : bus.dplca_aging ? m_age_cnt + 1 : 0;
        m_exp_age = age;
        m_exp_id = bid;
        m_exp_nc = m_cm + 1 > 255 ? 255 : m_cm + 1;
        m_cm = extra >= 0 ? extra : 0;
    endtask

    task automatic wait_upd(input int k0, input string tag);
        int k = k0;
        do begin
            tick();
            k++;
        end while (!bus.dplca_txop_table_upd && k < 300);
        m_cycles++;
        m_mh = m_max_hard();
        m_pf = m_pick_free(int'(bus.plca_node_count));
        checks++;
        if (k != 258) begin errors++; $display("FAIL %s latency got %0d want 258", tag, k); end
        checks++;
        if (bus.dplca_new_age !== m_exp_age) begin errors++; $display("FAIL %s new_age got %0b want %0b", tag, bus.dplca_new_age, m_exp_age); end
        checks++;
        if (bus.dplca_txop_id !== 8'(m_exp_id)) begin errors++; $display("FAIL %s txop_id got %0d want %0d", tag, bus.dplca_txop_id, m_exp_id); end
        checks++;
        if (bus.dplca_txop_node_count !== 8'(m_exp_nc)) begin errors++; $display("FAIL %s node_count got %0d want %0d", tag, bus.dplca_txop_node_count, m_exp_nc); end
        checks++;
        if (bus.max_hard_claim !== 8'(m_mh)) begin errors++; $display("FAIL %s max_hard_claim got %0d want %0d", tag, bus.max_hard_claim, m_mh); end
        checks++;
        if (bus.pick_free_txop !== 8'(m_pf)) begin errors++; $display("FAIL %s pick_free_txop got %0d want %0d", tag, bus.pick_free_txop, m_pf); end
        checks++;
        if (bus.txop_claim_table_unpacked !== m_table()) begin errors++; $display("FAIL %s table got %h want %h", tag, bus.txop_claim_table_unpacked[63:0], m_table()[63:0]); end
        tick();
        checks++;
        if (bus.dplca_txop_table_upd !== 1'b0 || bus.dplca_new_age !== 1'b0) begin errors++; $display("FAIL %s pulse_width upd=%0b new_age=%0b want 0", tag, bus.dplca_txop_table_upd, bus.dplca_new_age); end
    endtask

    task automatic check_no_upd(input int n, input string tag);
        int seen_upd = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.dplca_txop_table_upd === 1'b1) seen_upd++;
        end
        checks++;
        if (seen_upd != 0) begin errors++; $display("FAIL %s unexpected_upd got %0d want 0", tag, seen_upd); end
    endtask

    task automatic test_reset();
        bus.dplca_aging = 1'b1;
        bus.beacon_rx = 1'b0;
        bus.txop_active = 1'b0;
        bus.txop_id = '0;
        bus.plca_node_count = 8'd8;
        for (int i = 0; i < 256; i++) begin m_tbl[i] = 0; m_seen[i] = 1'b0; end
        m_age_cnt = 0; m_cm = 0; m_cycles = 0; m_overruns = 0;
        #12;
        checks++;
        if (bus.dplca_txop_table_upd !== 1'b0 || bus.dplca_new_age !== 1'b0) begin errors++; $display("FAIL reset pulses upd=%0b new_age=%0b want 0", bus.dplca_txop_table_upd, bus.dplca_new_age); end
        checks++;
        if (bus.pick_free_txop !== 8'hff || bus.max_hard_claim !== 8'h00) begin errors++; $display("FAIL reset results pick=%0d max=%0d want 255 0", bus.pick_free_txop, bus.max_hard_claim); end
        checks++;
        if (bus.dplca_txop_id !== 8'h00 || bus.dplca_txop_node_count !== 8'h00 || bus.txop_claim_table_unpacked !== '0) begin errors++; $display("FAIL reset id=%0d nc=%0d table_nonzero=%0b want 0", bus.dplca_txop_id, bus.dplca_txop_node_count, |bus.txop_claim_table_unpacked); end
        @(negedge clk);
        plca_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int k;
        pulse_active(0); pulse_active(3); pulse_active(5);
        send_beacon(0, -1, k);
        wait_upd(k, "basic");
    endtask

    task automatic test_aging();
        int k;
        for (int c = 0; c < 8; c++) begin
            tick(); pulse_active(3);
            send_beacon(c, -1, k);
            wait_upd(k, "aging_a");
        end
        for (int c = 0; c < 16; c++) begin
            pulse_active(3);
            send_beacon(3, -1, k);
            wait_upd(k, "aging_b");
        end
        checks++;
        if (bus.max_hard_claim !== 8'd3 || m_tbl[5] != 0) begin errors++; $display("FAIL aging_window max_hard_claim got %0d want 3 (model entry5 %0d)", bus.max_hard_claim, m_tbl[5]); end
    endtask

    task automatic test_same_clock_set();
        int k;
        while (m_age_cnt != AGE_N - 1) begin
            send_beacon(1, -1, k);
            wait_upd(k, "pre_age");
        end
        send_beacon(2, 7, k);
        wait_upd(k, "same_clock");
        for (int c = 0; c < AGE_N; c++) begin
            send_beacon(4, -1, k);
            wait_upd(k, "after_same_clock");
        end
    endtask

    task automatic test_overrun();
        int k;
        pulse_active(9);
        send_beacon(2, -1, k);
        check_no_upd(100, "overrun_first");
        m_overruns++;
        send_beacon(4, -1, k);
        wait_upd(k, "overrun_second");
`ifdef DPLCA_TXOP_STATS_EN
        checks++;
        if (bus.dplca_overrun_cnt !== 8'(m_overruns) || bus.dplca_cycle_cnt !== 16'(m_cycles)) begin errors++; $display("FAIL stats overrun=%0d cycles=%0d want %0d %0d", bus.dplca_overrun_cnt, bus.dplca_cycle_cnt, m_overruns, m_cycles); end
`endif
    endtask

    task automatic test_aging_fall();
        int k;
        send_beacon(1, -1, k);
        check_no_upd(50, "fall_pre");
        bus.dplca_aging = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin m_tbl[i] = 0; m_seen[i] = 1'b0; end
        m_age_cnt = 0;
        checks++;
        if (bus.txop_claim_table_unpacked !== '0) begin errors++; $display("FAIL fall_clear table got %h want 0", bus.txop_claim_table_unpacked[63:0]); end
        check_no_upd(300, "fall_abort");
        checks++;
        if (bus.pick_free_txop !== 8'(m_pf) || bus.max_hard_claim !== 8'(m_mh)) begin errors++; $display("FAIL fall_hold pick=%0d max=%0d want %0d %0d", bus.pick_free_txop, bus.max_hard_claim, m_pf, m_mh); end
        bus.dplca_aging = 1'b1;
        tick();
        send_beacon(6, -1, k);
        wait_upd(k, "after_fall");
    endtask

    task automatic test_random();
        int k, n;
        for (int c = 0; c < 10; c++) begin
            bus.plca_node_count = 8'($urandom_range(2, 20));
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) pulse_active($urandom_range(0, 20));
            send_beacon($urandom_range(0, 255), -1, k);
            wait_upd(k, "random");
        end
    endtask

    task automatic test_no_free();
        int k;
        bus.plca_node_count = 8'd8;
        for (int i = 1; i < 8; i++) pulse_active(i);
        send_beacon(7, -1, k);
        wait_upd(k, "no_free");
        checks++;
        if (bus.pick_free_txop !== 8'hff) begin errors++; $display("FAIL no_free pick got %0d want 255", bus.pick_free_txop); end
    endtask

    task automatic test_reset_mid_scan();
        int k;
        send_beacon(9, -1, k);
        check_no_upd(100, "mid_scan");
        plca_reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dplca_txop_id !== 8'h00 || bus.max_hard_claim !== 8'h00 || bus.pick_free_txop !== 8'hff || bus.dplca_txop_node_count !== 8'h00) begin errors++; $display("FAIL async_reset id=%0d max=%0d pick=%0d nc=%0d", bus.dplca_txop_id, bus.max_hard_claim, bus.pick_free_txop, bus.dplca_txop_node_count); end
        checks++;
        if (bus.txop_claim_table_unpacked !== '0 || bus.dplca_txop_table_upd !== 1'b0) begin errors++; $display("FAIL async_reset table_nonzero=%0b upd=%0b want 0", |bus.txop_claim_table_unpacked, bus.dplca_txop_table_upd); end
        #20;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aging();
        test_same_clock_set();
        test_overrun();
        test_aging_fall();
        test_random();
        test_no_free();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
